// File: rtl/mux_feed_if.sv
// Operand-load, sequence-control and mux-feed signals between the sequencer and its neighbours.
interface mux_feed_if #(
  parameter int unsigned WIDTH = 32
);
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [2:0]       seq_len;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, start, seq_len, out_ready,
    input  a, b, c, d, sel, out_valid, busy, done, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, seq_len, out_ready,
    output a, b, c, d, sel, out_valid, busy, done, wr_err
  );
endinterface

// File: rtl/mux_feed_seq.sv
// Sequencer feeding a 4-to-1 mux: four operand registers plus a select stepper
// that walks 0..L-1 under a valid/ready handshake.
module mux_feed_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_feed_if.slave bus
);

  localparam int unsigned NREG  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned LEN_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_err_q, wr_err_d;
  logic             wr_ok_c;
  logic [SEL_W-1:0] len_last_c;

  // Index of the final entry: lengths 1..4 map to 0..3, anything else means a full sweep.
  always_comb begin
    len_last_c = SEL_W'(3);
    if (bus.seq_len != LEN_W'(0) && bus.seq_len <= LEN_W'(4)) begin
      len_last_c = SEL_W'(bus.seq_len - LEN_W'(1));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave RUN once the last entry is accepted, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (bus.out_ready && sel_q == last_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; everything visible is registered below.
  always_comb begin
    sel_d    = sel_q;
    last_d   = last_q;
    wr_ok_c  = 1'b0;
    wr_err_d = bus.wr_en && (state_q != IDLE);
    valid_d  = (state_d == RUN);
    busy_d   = (state_d == RUN);
    done_d   = (state_d == DONE);
    case (state_q)
      IDLE: begin
        wr_ok_c = bus.wr_en;
        if (bus.start) begin
          sel_d  = SEL_W'(0);
          last_d = len_last_c;
        end
      end
      RUN: begin
        // The last entry keeps its select so it remains visible after the sequence.
        if (bus.out_ready && sel_q != last_q) sel_d = sel_q + SEL_W'(1);
      end
      default: ;
    endcase
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      last_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Operand registers: only IDLE writes land, a sequence never touches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_ok_c) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.a         = regs_q[0];
  assign bus.b         = regs_q[1];
  assign bus.c         = regs_q[2];
  assign bus.d         = regs_q[3];
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wr_err    = wr_err_q;

endmodule

// File: doc/mux_feed_seq.md
# mux_feed_seq

Upstream sequencer for the 4-to-1 32-bit mux stage. It holds four 32-bit operand registers that drive the mux data inputs a/b/c/d. On command it steps the mux select through a programmed number of entries, one entry per accepted handshake. Downstream logic reads the mux output `o` while `out_valid` is high and acknowledges each entry with `out_ready`.

## Interface

Parameters:
- WIDTH, 32, data width of each operand register and of a/b/c/d

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe for the operand registers
- wr_addr  in  2  target register (0=a, 1=b, 2=c, 3=d)
- wr_data  in  WIDTH  write data
- start  in  1  begin a sequence (honoured in IDLE only)
- seq_len  in  3  number of entries to emit, sampled at start; 0 or >4 treated as 4
- out_ready  in  1  downstream accepts current entry
- a, b, c, d  out  WIDTH  operand registers, wired to mux inputs
- sel  out  2  mux select
- out_valid  out  1  current sel/operand pair is valid
- busy  out  1  sequence in progress (state RUN)
- done  out  1  one-cycle pulse after last entry accepted
- wr_err  out  1  one-cycle pulse when a write is dropped

## Operation

- One clock; reset is asynchronous and active-low.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - wr_en writes wr_data into register[wr_addr] at the clock edge.
  - start=1 latches the effective length L (1..4), sets sel=0, and moves to RUN.
- RUN:
  - out_valid=1 and busy=1.
  - A transfer occurs on an edge where out_valid && out_ready. After a transfer, sel increments.
  - If the transfer was entry L-1, the next state is DONE.
  - out_ready=0 holds sel and out_valid unchanged for any number of cycles.
- DONE:
  - out_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
  - sel holds the last emitted value until the next start.
- Writes in RUN or DONE are dropped: the register is unchanged and wr_err pulses on the next cycle.
- start in RUN or DONE is ignored. No error is flagged and no queuing occurs.
- wr_en and start in the same IDLE cycle: both take effect. The first emitted entry reflects the new write.
- Operand registers change only through writes. A sequence never modifies them, so a second start replays the same data.
- Length decode: seq_len 1..4 gives L=seq_len; 0, 5, 6 and 7 give L=4.
- sel counts 0..L-1 only and never wraps within a sequence.

## Timing

- Reset (rst_n=0, asynchronous): a=b=c=d=0, sel=0, out_valid=0, busy=0, done=0, wr_err=0, state=IDLE. This applies immediately, without waiting for a clock edge.
- Reset asserted mid-RUN aborts the sequence. No done pulse is produced.
- Write latency: register output updates 1 cycle after the wr_en edge.
- Start latency: out_valid=1 with sel=0 in the cycle after the start edge.
- With out_ready held at 1, a sequence of L entries takes:
  - L cycles with out_valid=1,
  - then 1 cycle of done=1,
  - then IDLE.
  - Earliest restart is the edge in the cycle after done, giving L+2 cycles per sequence.
- sel and out_valid are registered outputs, so there is no combinational path from out_ready to them.
- wr_err and done are registered single-cycle pulses.

## Test plan

- **Reset:** drive rst_n=0 mid-RUN (sel=2) → all outputs 0 asynchronously, state IDLE, no done pulse; after release, sel=0 and out_valid=0.
- **Load and full sweep:** write a=FFFFFFFF, b=AAAAAAAA, c=00000000, d=11111111; start with seq_len=0 and out_ready=1.
  - sel steps 0,1,2,3 on consecutive cycles with out_valid=1.
  - Mux output reads FFFFFFFF, AAAAAAAA, 00000000, 11111111.
  - done pulses once, then IDLE.
- **Back-pressure:** seq_len=3, out_ready toggling 1,0,0,1,1 → sel holds at 1 through both stall cycles; exactly 3 transfers (sel 0,1,2); done after the third.
- **Dropped write:** write wr_addr=2, wr_data=DEADBEEF during RUN → c stays 00000000, wr_err pulses 1 cycle, sequence unaffected.
- **Simultaneous write and start in IDLE:** wr_addr=0, wr_data=12345678, start=1, seq_len=1 → one entry sel=0 with a=12345678, then done.
- **Ignored start:** assert start during RUN and DONE → no restart and no extra entries; a start on the first IDLE cycle begins a new sequence at sel=0.
